// File: rtl/booth_mul_pipe_if.sv
// Handshake bundle for booth_mul_pipe: request side (operands, modes, tag)
// and response side (product, tag), each with its own valid/ready pair.
interface booth_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               a_signed;
    logic               b_signed;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, a_signed, b_signed, multiplicand, multiplier, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, a_signed, b_signed, multiplicand, multiplier, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag
    );
endinterface

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier with whole-pipe valid/ready flow control,
// per-operand signed/unsigned mode and a tag travelling alongside each operation.
module booth_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int TAG_W  = 4
) (
    input logic             clk,
    input logic             rst,
    booth_mul_pipe_if.slave bus
);
    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int ND = EW / 2;

    // Booth digits are spread evenly over the stages; stage s owns digit i
    // when i*STAGES/ND == s, so deep pipelines may have digit-free stages.
    function automatic int digit_stage(input int idx);
        return (idx * STAGES) / ND;
    endfunction

    function automatic logic signed [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
        return {{2{sgn & v[WIDTH-1]}}, v};
    endfunction

    // Partial product in one's-complement form; neg flags the +1 correction.
    function automatic logic [PW-1:0] booth_pp(input logic signed [EW-1:0] a,
                                               input logic [2:0] trip,
                                               output logic neg);
        logic [PW-1:0] a_w;
        logic [PW-1:0] mag;
        a_w = {{(PW-EW){a[EW-1]}}, a};
        mag = '0;
        neg = 1'b0;
        case (trip)
            3'b001, 3'b010: mag = a_w;
            3'b011:         mag = a_w << 1;
            3'b100: begin   mag = a_w << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_w; neg = 1'b1; end
            default:        mag = '0;
        endcase
        return neg ? ~mag : mag;
    endfunction

    logic                 vld_p   [STAGES];
    logic [TAG_W-1:0]     tag_p   [STAGES];
    logic signed [EW-1:0] a_p     [STAGES];
    logic signed [EW-1:0] b_p     [STAGES];
    logic signed [PW-1:0] acc_p   [STAGES];

    logic                 vld_in  [STAGES];
    logic [TAG_W-1:0]     tag_in  [STAGES];
    logic signed [EW-1:0] a_in    [STAGES];
    logic signed [EW-1:0] b_in    [STAGES];
    logic signed [PW-1:0] acc_in  [STAGES];
    logic signed [PW-1:0] acc_nxt [STAGES];

    logic advance;

    assign advance      = !vld_p[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    // ---- stage inputs: stage 0 takes the extended operands, later stages chain
    always_comb begin
        vld_in[0] = bus.in_valid;
        tag_in[0] = bus.in_tag;
        a_in[0]   = extend(bus.multiplicand, bus.a_signed);
        b_in[0]   = extend(bus.multiplier, bus.b_signed);
        acc_in[0] = '0;
        for (int s = 1; s < STAGES; s++) begin
            vld_in[s] = vld_p[s-1];
            tag_in[s] = tag_p[s-1];
            a_in[s]   = a_p[s-1];
            b_in[s]   = b_p[s-1];
            acc_in[s] = acc_p[s-1];
        end
    end

    // ---- per-stage reduction: accumulate this stage's share of the digits
    always_comb begin
        logic [EW:0]   b_pad;
        logic [PW-1:0] pp;
        logic          neg;
        b_pad = '0;
        pp    = '0;
        neg   = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            acc_nxt[s] = acc_in[s];
            b_pad      = {b_in[s], 1'b0};
            for (int i = 0; i < ND; i++) begin
                if (digit_stage(i) == s) begin
                    pp         = booth_pp(a_in[s], b_pad[2*i +: 3], neg);
                    acc_nxt[s] = acc_nxt[s] + $signed(pp << (2*i))
                                            + $signed(PW'(neg) << (2*i));
                end
            end
        end
    end

    // ---- stage registers: the whole pipe moves together on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s] <= 1'b0;
                tag_p[s] <= '0;
                a_p[s]   <= '0;
                b_p[s]   <= '0;
                acc_p[s] <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s] <= vld_in[s];
                if (vld_in[s]) begin
                    tag_p[s] <= tag_in[s];
                    a_p[s]   <= a_in[s];
                    b_p[s]   <= b_in[s];
                    acc_p[s] <= acc_nxt[s];
                end
            end
        end
    end

    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.result    = acc_p[STAGES-1];
    assign bus.out_tag   = tag_p[STAGES-1];
endmodule
